ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 69 ++++++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if -- request/grant bundle between two RAM requesters (CPU and
// boot loader), the arbiter, and the single-port RAM it drives.
//
// Handshake: x_req is the "valid" and x_gnt is the "ready". A requester raises
// x_req together with x_rw/x_adr/x_din and keeps all four stable until the
// cycle in which x_gnt is high. That gnt cycle is the transfer: the request is
// issued to the RAM in that same cycle and is consumed. A read returns
// x_rvalid exactly one cycle later, with the data on the RAM output. Writes
// never produce x_rvalid.
//
// Signals:
//   ce, boot                      clock enable and boot mode
//   cpu_* / boot_*                per-requester req, rw, adr, din, gnt, rvalid
//   boot_lock                     burst lock request from the boot loader
//   ram_enable/ram_rw/ram_adr/ram_in  command to the single-port RAM
//   conflict_cnt                  saturating count of contended cycles
//   dbg_state                     owner FSM state (0 IDLE, 1 CPU, 2 BOOT)
//
// Modports: slave = the arbiter, master = whoever drives the requests.
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16
);
  logic              ce;
  logic              boot;

  logic              cpu_req;
  logic              cpu_rw;
  logic [ADR_W-1:0]  cpu_adr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              boot_req;
  logic              boot_rw;
  logic [ADR_W-1:0]  boot_adr;
  logic [DATA_W-1:0] boot_din;
  logic              boot_lock;
  logic              boot_gnt;
  logic              boot_rvalid;

  logic              ram_enable;
  logic              ram_rw;
  logic [ADR_W-1:0]  ram_adr;
  logic [DATA_W-1:0] ram_in;

  logic [7:0]        conflict_cnt;
  logic [1:0]        dbg_state;

  modport slave (
    input  ce, boot,
    input  cpu_req, cpu_rw, cpu_adr, cpu_din,
    input  boot_req, boot_rw, boot_adr, boot_din, boot_lock,
    output cpu_gnt, cpu_rvalid, boot_gnt, boot_rvalid,
    output ram_enable, ram_rw, ram_adr, ram_in,
    output conflict_cnt, dbg_state
  );

  modport master (
    output ce, boot,
    output cpu_req, cpu_rw, cpu_adr, cpu_din,
    output boot_req, boot_rw, boot_adr, boot_din, boot_lock,
    input  cpu_gnt, cpu_rvalid, boot_gnt, boot_rvalid,
    input  ram_enable, ram_rw, ram_adr, ram_in,
    input  conflict_cnt, dbg_state
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter -- round-robin arbiter sharing one single-port RAM between a CPU
// and a boot loader.
//
// Grants are combinational from the current requests and the registered owner
// state, so a request can be issued to the RAM in the cycle it appears. The
// owner FSM (IDLE, CPU, BOOT) remembers who was granted last; with both
// requesting, the other one wins, and from IDLE the CPU wins. In boot mode the
// CPU is never granted.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   ram_arbiter_if.slave (requests, grants, rvalids, RAM command,
//         conflict counter, FSM state for debug)
//
// Build option:
//   RAM_ARB_BOOT_LOCK_EN  when defined, boot_lock held high while the boot
//                         loader owns the RAM keeps the grant with the boot
//                         loader until boot_lock falls. When undefined,
//                         boot_lock is ignored.
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    BOOT = 2'd2
  } owner_e;

  owner_e            state;
  owner_e            state_next;

  logic              active;
  logic              lock_hold;
  logic              cpu_cand;
  logic              boot_cand;
  logic              cpu_gnt;
  logic              boot_gnt;
  logic              contended;

  logic              cpu_rv_q;
  logic              boot_rv_q;
  logic [7:0]        conflict_q;

  logic              en_mux;
  logic              rw_mux;
  logic [ADR_W-1:0]  adr_mux;
  logic [DATA_W-1:0] din_mux;

  // Nothing is granted while the block is frozen or being reset.
  assign active = bus.ce & ~rst;

`ifdef RAM_ARB_BOOT_LOCK_EN
  // The lock only takes effect once the boot loader already owns the RAM,
  // so it cannot be used to pre-empt a CPU that was granted last.
  assign lock_hold = (state == BOOT) & bus.boot_lock;
`else
  logic boot_lock_unused;
  assign boot_lock_unused = bus.boot_lock;
  assign lock_hold        = 1'b0;
`endif

  assign cpu_cand  = active & bus.cpu_req & ~bus.boot & ~lock_hold;
  assign boot_cand = active & bus.boot_req;

  // Contention is counted on the raw requests, independent of the lock.
  assign contended = bus.cpu_req & bus.boot_req & ~bus.boot;

  // -------------------------------------------------------------------------
  // Owner FSM: next state and grants.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = IDLE;
    cpu_gnt    = 1'b0;
    boot_gnt   = 1'b0;

    if (cpu_cand && boot_cand) begin
      // Round-robin: the one not granted last wins; IDLE favours the CPU.
      if (state == CPU) begin
        boot_gnt = 1'b1;
      end else begin
        cpu_gnt  = 1'b1;
      end
    end else if (cpu_cand) begin
      cpu_gnt  = 1'b1;
    end else if (boot_cand) begin
      boot_gnt = 1'b1;
    end

    if (cpu_gnt) begin
      state_next = CPU;
    end else if (boot_gnt) begin
      state_next = BOOT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.ce) begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read-valid pipeline and conflict counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rv_q   <= 1'b0;
      boot_rv_q  <= 1'b0;
      conflict_q <= 8'd0;
    end else if (bus.ce) begin
      cpu_rv_q  <= cpu_gnt & ~bus.cpu_rw;
      boot_rv_q <= boot_gnt & ~bus.boot_rw;
      if (contended && (conflict_q != 8'hFF)) begin
        conflict_q <= conflict_q + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // RAM command mux: zeros whenever nothing is granted.
  // -------------------------------------------------------------------------
  always_comb begin
    en_mux  = 1'b0;
    rw_mux  = 1'b0;
    adr_mux = '0;
    din_mux = '0;
    if (cpu_gnt) begin
      en_mux  = 1'b1;
      rw_mux  = bus.cpu_rw;
      adr_mux = bus.cpu_adr;
      din_mux = bus.cpu_din;
    end else if (boot_gnt) begin
      en_mux  = 1'b1;
      rw_mux  = bus.boot_rw;
      adr_mux = bus.boot_adr;
      din_mux = bus.boot_din;
    end
  end

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.boot_gnt     = boot_gnt;

  // A read granted just before reset must not show up while reset is high:
  // the registered flag is masked so the pulse is suppressed in that cycle.
  assign bus.cpu_rvalid   = cpu_rv_q & ~rst;
  assign bus.boot_rvalid  = boot_rv_q & ~rst;

  assign bus.ram_enable   = en_mux;
  assign bus.ram_rw       = rw_mux;
  assign bus.ram_adr      = adr_mux;
  assign bus.ram_in       = din_mux;

  assign bus.conflict_cnt = conflict_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter -- directed bench for ram_arbiter. A table of one-cycle
// vectors covers the main arbitration behaviour; hand-written sequences cover
// the boot lock, reset after a read grant and counter saturation.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int ADR_W  = 6;
  localparam int DATA_W = 16;
  localparam int NVEC   = 21;

  // ----- clock / reset -----
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ----- vector record: inputs for one cycle, expected outputs in it -----
  typedef struct {
    logic              rst;
    logic              ce;
    logic              boot;
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADR_W-1:0]  cpu_adr;
    logic [DATA_W-1:0] cpu_din;
    logic              boot_req;
    logic              boot_rw;
    logic [ADR_W-1:0]  boot_adr;
    logic [DATA_W-1:0] boot_din;
    logic              boot_lock;
    logic              e_cpu_gnt;
    logic              e_boot_gnt;
    logic              e_cpu_rv;
    logic              e_boot_rv;
    logic              e_en;
    logic              e_rw;
    logic [ADR_W-1:0]  e_adr;
    logic [DATA_W-1:0] e_din;
    logic [7:0]        e_cnt;
    logic [1:0]        e_st;
  } vec_t;

  vec_t vecs[NVEC];

  // ----- scoreboard -----
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ----- driver tasks -----
  task automatic set_in(input logic r, input logic ce, input logic boot,
                        input logic creq, input logic crw, input logic [ADR_W-1:0] cadr,
                        input logic [DATA_W-1:0] cdin,
                        input logic breq, input logic brw, input logic [ADR_W-1:0] badr,
                        input logic [DATA_W-1:0] bdin, input logic lock);
    rst          = r;
    bus.ce       = ce;
    bus.boot     = boot;
    bus.cpu_req  = creq;
    bus.cpu_rw   = crw;
    bus.cpu_adr  = cadr;
    bus.cpu_din  = cdin;
    bus.boot_req = breq;
    bus.boot_rw  = brw;
    bus.boot_adr = badr;
    bus.boot_din = bdin;
    bus.boot_lock = lock;
  endtask

  task automatic drive(input vec_t v);
    set_in(v.rst, v.ce, v.boot, v.cpu_req, v.cpu_rw, v.cpu_adr, v.cpu_din,
           v.boot_req, v.boot_rw, v.boot_adr, v.boot_din, v.boot_lock);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ce bt cq cw cadr  cdin     bq bw badr  bdin     lk | cg bg crv brv en rw adr   din      cnt st
    vecs[0]  = '{1,1,0, 1,0,'h05,'h0000, 1,0,'h02,'h0000, 0,  0,0,0,0, 0,0,'h00,'h0000, 0,0}; // reset: no gnt
    vecs[1]  = '{0,1,0, 1,0,'h05,'h0000, 0,0,'h00,'h0000, 0,  1,0,0,0, 1,0,'h05,'h0000, 0,0}; // cpu read 0x05
    vecs[2]  = '{0,1,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,1,0, 0,0,'h00,'h0000, 0,1}; // cpu rvalid
    vecs[3]  = '{0,1,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,0,0, 0,0,'h00,'h0000, 0,0}; // back to idle
    vecs[4]  = '{0,1,0, 1,0,'h11,'hAAAA, 1,1,'h22,'h1234, 0,  1,0,0,0, 1,0,'h11,'hAAAA, 0,0}; // both: cpu from idle
    vecs[5]  = '{0,1,0, 1,0,'h11,'hAAAA, 1,1,'h22,'h1234, 0,  0,1,1,0, 1,1,'h22,'h1234, 1,1}; // boot
    vecs[6]  = '{0,1,0, 1,0,'h11,'hAAAA, 1,1,'h22,'h1234, 0,  1,0,0,0, 1,0,'h11,'hAAAA, 2,2}; // cpu
    vecs[7]  = '{0,1,0, 1,0,'h11,'hAAAA, 1,1,'h22,'h1234, 0,  0,1,1,0, 1,1,'h22,'h1234, 3,1}; // boot
    vecs[8]  = '{0,1,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,0,0, 0,0,'h00,'h0000, 4,2}; // cnt=4, no rv for write
    vecs[9]  = '{0,1,0, 0,0,'h00,'h0000, 1,0,'h07,'h5555, 0,  0,1,0,0, 1,0,'h07,'h5555, 4,0}; // boot read only
    vecs[10] = '{0,1,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,0,1, 0,0,'h00,'h0000, 4,2}; // boot rvalid
    vecs[11] = '{0,1,1, 1,0,'h01,'h0101, 1,0,'h02,'h0202, 0,  0,1,0,0, 1,0,'h02,'h0202, 4,0}; // boot mode
    vecs[12] = '{0,1,1, 1,0,'h01,'h0101, 1,0,'h02,'h0202, 0,  0,1,0,1, 1,0,'h02,'h0202, 4,2};
    vecs[13] = '{0,1,1, 1,0,'h01,'h0101, 1,0,'h02,'h0202, 0,  0,1,0,1, 1,0,'h02,'h0202, 4,2};
    vecs[14] = '{0,1,1, 1,0,'h01,'h0101, 0,0,'h00,'h0000, 0,  0,0,0,1, 0,0,'h00,'h0000, 4,2}; // cpu waits
    vecs[15] = '{0,1,0, 1,0,'h01,'h0101, 0,0,'h00,'h0000, 0,  1,0,0,0, 1,0,'h01,'h0101, 4,0}; // boot off: cpu
    vecs[16] = '{0,0,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,1,0, 0,0,'h00,'h0000, 4,1}; // ce=0 holds
    vecs[17] = '{0,0,0, 0,0,'h00,'h0000, 1,1,'h3F,'hBEEF, 0,  0,0,1,0, 0,0,'h00,'h0000, 4,1}; // no gnt at ce=0
    vecs[18] = '{0,1,0, 0,0,'h00,'h0000, 1,1,'h3F,'hBEEF, 0,  0,1,1,0, 1,1,'h3F,'hBEEF, 4,1}; // write issued
    vecs[19] = '{0,0,0, 1,0,'h01,'h0000, 1,1,'h3F,'hBEEF, 0,  0,0,0,0, 0,0,'h00,'h0000, 4,2}; // ce=0: no count
    vecs[20] = '{0,1,0, 0,0,'h00,'h0000, 0,0,'h00,'h0000, 0,  0,0,0,0, 0,0,'h00,'h0000, 4,2}; // held through ce=0

    // ----- reset -----
    set_in(1,1,0, 0,0,'0,'0, 0,0,'0,'0, 0);
    next_cycle();
    next_cycle();

    // ----- table-driven vectors -----
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {26'd0, bus.cpu_gnt, bus.boot_gnt, bus.cpu_rvalid, bus.boot_rvalid,
           bus.ram_enable, bus.ram_rw, bus.ram_adr, bus.ram_in, bus.conflict_cnt, bus.dbg_state},
          {26'd0, vecs[i].e_cpu_gnt, vecs[i].e_boot_gnt, vecs[i].e_cpu_rv, vecs[i].e_boot_rv,
           vecs[i].e_en, vecs[i].e_rw, vecs[i].e_adr, vecs[i].e_din, vecs[i].e_cnt, vecs[i].e_st});
      next_cycle();
    end

    // ----- boot lock: one boot grant, 3 locked cycles, then release -----
    exp_q.push_back(2'b01);
`ifdef RAM_ARB_BOOT_LOCK_EN
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
`else
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
`endif
    for (int c = 0; c < 5; c++) begin
      logic [1:0] e;
      if (c == 0) set_in(0,1,0, 0,0,'h20,'h0000, 1,1,'h10,'h0001, 0);
      else if (c < 4) set_in(0,1,0, 1,0,'h20,'h0000, 1,1,'h10,'h0001, 1);
      else set_in(0,1,0, 1,0,'h20,'h0000, 1,1,'h10,'h0001, 0);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("lock_gnt%0d", c), {62'd0, bus.cpu_gnt, bus.boot_gnt}, {62'd0, e});
      next_cycle();
    end
    set_in(0,1,0, 0,0,'0,'0, 0,0,'0,'0, 0);
    @(negedge clk);
    chk("lock_cnt", {56'd0, bus.conflict_cnt}, 64'd8);
    next_cycle();

    // ----- reset in the cycle after a cpu read grant (ce low in reset) -----
    set_in(0,1,0, 1,0,'h05,'h0000, 0,0,'0,'0, 0);
    @(negedge clk);
    chk("rst_pre_gnt", {63'd0, bus.cpu_gnt}, 64'd1);
    next_cycle();
    set_in(1,0,0, 1,0,'h05,'h0000, 1,0,'h06,'0, 0);
    @(negedge clk);
    chk("rst_no_rvalid", {63'd0, bus.cpu_rvalid}, 64'd0);
    chk("rst_no_gnt", {61'd0, bus.cpu_gnt, bus.boot_gnt, bus.ram_enable}, 64'd0);
    next_cycle();
    set_in(0,1,0, 0,0,'0,'0, 0,0,'0,'0, 0);
    @(negedge clk);
    chk("rst_after", {53'd0, bus.cpu_rvalid, bus.conflict_cnt, bus.dbg_state}, 64'd0);
    next_cycle();

    // ----- conflict counter saturation -----
    for (int i = 0; i < 260; i++) begin
      set_in(0,1,0, 1,0,'h01,'0, 1,0,'h02,'0, 0);
      @(negedge clk);
      if (i == 254) chk("cnt_254", {56'd0, bus.conflict_cnt}, 64'd254);
      if (i == 255) chk("cnt_255", {56'd0, bus.conflict_cnt}, 64'd255);
      if (i == 259) chk("cnt_sat", {56'd0, bus.conflict_cnt}, 64'd255);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
